// File: rtl/seg_tx_pkg.sv
// Shared types and constants for the segment-pattern serial transmitter.
package seg_tx_pkg;

    localparam int NBITS = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/seg_tx_tick.sv
// Half-period tick generator: pulses once every DIV enabled cycles, restartable on clr.
module seg_tx_tick #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(DIV) + 1;

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;
    logic          at_wrap;

    assign at_wrap = (div_cnt_q == CW'(DIV - 1));
    assign tick    = en && at_wrap;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr) begin
            div_cnt_d = '0;
        end else if (en) begin
            div_cnt_d = at_wrap ? '0 : div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/seg_shift_tx.sv
// Shifts a captured 64-bit segment pattern MSB-first into a 74HC595-style chain,
// then pulses the parallel-load enable for one half period.
module seg_shift_tx #(
    parameter int DIV   = 2,
    parameter int NBITS = seg_tx_pkg::NBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NBITS-1:0] seg_txt,
    output logic             busy,
    output logic             done,
    output logic             s_clk,
    output logic             s_dat,
    output logic             s_pen,
    output logic             s_clrn
);

    import seg_tx_pkg::*;

    localparam int CNT_W = $clog2(NBITS) + 1;

    if (DIV < 1) begin : g_div_chk
        $error("seg_shift_tx: DIV must be at least 1");
    end
    if (NBITS != 64) begin : g_nbits_chk
        $error("seg_shift_tx: NBITS is fixed at 64");
    end

    state_e             state_q, state_d;
    logic [NBITS-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               s_clk_q, s_clk_d;
    logic               s_dat_q, s_dat_d;
    logic               s_pen_q, s_pen_d;
    logic               s_clrn_q, s_clrn_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;
    logic               tick;
    logic               tick_en;

    assign tick_en = (state_q == SHIFT) || (state_q == LATCH);

    seg_tx_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .clr   (accept),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        s_clk_d   = s_clk_q;
        s_dat_d   = s_dat_q;
        s_pen_d   = s_pen_q;
        s_clrn_d  = 1'b1;
        busy_d    = busy_q;
        done_d    = 1'b0;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                s_clk_d = 1'b0;
                s_pen_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    accept    = 1'b1;
                    shreg_d   = seg_txt;
                    s_dat_d   = seg_txt[NBITS-1];
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!s_clk_q) begin
                        s_clk_d = 1'b1;
                    end else begin
                        // Data only moves on the falling edge, giving a full half period of setup and hold.
                        s_clk_d   = 1'b0;
                        shreg_d   = {shreg_q[NBITS-2:0], 1'b0};
                        s_dat_d   = shreg_q[NBITS-2];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CNT_W'(NBITS - 1)) begin
                            s_pen_d = 1'b1;
                            state_d = LATCH;
                        end
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    s_pen_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            s_clk_q   <= 1'b0;
            s_dat_q   <= 1'b0;
            s_pen_q   <= 1'b0;
            s_clrn_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            s_clk_q   <= s_clk_d;
            s_dat_q   <= s_dat_d;
            s_pen_q   <= s_pen_d;
            s_clrn_q  <= s_clrn_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign s_clk  = s_clk_q;
    assign s_dat  = s_dat_q;
    assign s_pen  = s_pen_q;
    assign s_clrn = s_clrn_q;

endmodule
